// File: rtl/hex_sseg_mux_if.sv
// hex_sseg_mux_if: display bus between a digit source and the seven-segment mux.
//   hex        4*N_DIGITS  digit values, digit k = hex[4k+3:4k], digit 0 rightmost
//   dp         N_DIGITS    decimal point request per digit, 1 = lit
//   blank      N_DIGITS    per-digit blank request, 1 = dark
//   load       1           one-cycle strobe capturing hex/dp/blank
//   an         N_DIGITS    anode enables, active-low
//   sseg       8           cathodes, active-low, {dp,g,f,e,d,c,b,a}
//   frame_tick 1           one-cycle pulse after each frame boundary
// master drives the digit data, slave is the mux.
interface hex_sseg_mux_if #(
  parameter int unsigned N_DIGITS = 4
);
  logic [4*N_DIGITS-1:0] hex;
  logic [N_DIGITS-1:0]   dp;
  logic [N_DIGITS-1:0]   blank;
  logic                  load;
  logic [N_DIGITS-1:0]   an;
  logic [7:0]            sseg;
  logic                  frame_tick;

  modport master (
    output hex, dp, blank, load,
    input  an, sseg, frame_tick
  );

  modport slave (
    input  hex, dp, blank, load,
    output an, sseg, frame_tick
  );
endinterface

// File: rtl/hex_sseg_mux.sv
// hex_sseg_mux: time-multiplexed, double-buffered hex seven-segment driver.
// Ports:
//   clk      single clock, rising edge
//   reset_n  synchronous active-low reset
//   bus      hex_sseg_mux_if.slave (hex/dp/blank/load in, an/sseg/frame_tick out)
// Parameters: N_DIGITS (1..8), DIGIT_PERIOD (cycles per slot, >= GUARD_CYCLES+2),
//   GUARD_CYCLES (all-anodes-off cycles at slot start, 0 = no guard).
// Optional feature: define HEX_SSEG_MUX_LZB_EN for leading-zero blanking.
module hex_sseg_mux #(
  parameter int unsigned N_DIGITS     = 4,
  parameter int unsigned DIGIT_PERIOD = 65536,
  parameter int unsigned GUARD_CYCLES = 2
) (
  input  logic          clk,
  input  logic          reset_n,
  hex_sseg_mux_if.slave bus
);
  localparam int unsigned PW = (DIGIT_PERIOD > 1) ? $clog2(DIGIT_PERIOD) : 1;
  localparam int unsigned IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int unsigned HW = 4 * N_DIGITS;
  localparam logic [PW-1:0] PCNT_LAST = PW'(DIGIT_PERIOD - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(N_DIGITS - 1);

  logic [PW-1:0]       pcnt;
  logic [IW-1:0]       idx;
  logic [HW-1:0]       hex_a, hex_p;
  logic [N_DIGITS-1:0] dp_a, dp_p;
  logic [N_DIGITS-1:0] blank_a, blank_p;
  logic                pending_valid;
  logic [N_DIGITS-1:0] an_q;
  logic [7:0]          sseg_q;
  logic                tick_q;

  logic                slot_end_c, wrap_c, guard_c;
  logic [PW-1:0]       pcnt_nxt_c;
  logic [IW-1:0]       idx_nxt_c;
  logic [3:0]          digit_c;
  logic                dp_c, dark_c;
  logic [N_DIGITS-1:0] sup_c;
  logic [N_DIGITS-1:0] an_nxt_c;
  logic [7:0]          sseg_nxt_c;

  assign bus.an         = an_q;
  assign bus.sseg       = sseg_q;
  assign bus.frame_tick = tick_q;

  // Active-low g..a pattern for one hex digit.
  function automatic logic [6:0] seg7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0:    s = 7'b1000000;
      4'h1:    s = 7'b1111001;
      4'h2:    s = 7'b0100100;
      4'h3:    s = 7'b0110000;
      4'h4:    s = 7'b0011001;
      4'h5:    s = 7'b0010010;
      4'h6:    s = 7'b0000010;
      4'h7:    s = 7'b1111000;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0010000;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b0000011;
      4'hC:    s = 7'b1000110;
      4'hD:    s = 7'b0100001;
      4'hE:    s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  // Prescaler / digit index sequencing; wrap_c marks the frame boundary.
  always_comb begin
    slot_end_c = (pcnt == PCNT_LAST);
    wrap_c     = slot_end_c && (idx == IDX_LAST);
    pcnt_nxt_c = slot_end_c ? '0 : pcnt + PW'(1);
    idx_nxt_c  = idx;
    if (slot_end_c) begin
      idx_nxt_c = (idx == IDX_LAST) ? '0 : idx + IW'(1);
    end
  end

  // Ghosting guard at the start of each slot.
  generate
    if (GUARD_CYCLES == 0) begin : g_no_guard
      assign guard_c = 1'b0;
    end else begin : g_guard
      assign guard_c = (pcnt < PW'(GUARD_CYCLES));
    end
  endgenerate

`ifdef HEX_SSEG_MUX_LZB_EN
  // Leading-zero suppression: digit k>0 dark when it and every higher digit are 0, unless its dp is lit.
  always_comb begin
    logic zeros;
    zeros = 1'b1;
    sup_c = '0;
    for (int k = int'(N_DIGITS) - 1; k >= 1; k--) begin
      zeros    = zeros && (hex_a[4*k +: 4] == 4'h0);
      sup_c[k] = zeros && !dp_a[k];
    end
  end
`else
  assign sup_c = '0;
`endif

  // Select the active digit addressed by idx.
  always_comb begin
    digit_c = 4'h0;
    dp_c    = 1'b0;
    dark_c  = 1'b1;
    for (int unsigned k = 0; k < N_DIGITS; k++) begin
      if (idx == IW'(k)) begin
        digit_c = hex_a[4*k +: 4];
        dp_c    = dp_a[k];
        dark_c  = blank_a[k] | sup_c[k];
      end
    end
  end

  // Next anode / cathode values, registered below.
  always_comb begin
    an_nxt_c   = '1;
    sseg_nxt_c = 8'hFF;
    if (!guard_c) begin
      an_nxt_c = ~(N_DIGITS'(1) << idx);
      if (!dark_c) begin
        sseg_nxt_c = {~dp_c, seg7(digit_c)};
      end
    end
  end

  // State, double buffer and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pcnt          <= '0;
      idx           <= '0;
      hex_a         <= '0;
      dp_a          <= '0;
      blank_a       <= '1;
      hex_p         <= '0;
      dp_p          <= '0;
      blank_p       <= '1;
      pending_valid <= 1'b0;
      an_q          <= '1;
      sseg_q        <= 8'hFF;
      tick_q        <= 1'b0;
    end else begin
      pcnt   <= pcnt_nxt_c;
      idx    <= idx_nxt_c;
      tick_q <= wrap_c;
      an_q   <= an_nxt_c;
      sseg_q <= sseg_nxt_c;
      if (wrap_c) begin
        // A load landing on the boundary bypasses the pending buffer.
        if (bus.load) begin
          hex_a   <= bus.hex;
          dp_a    <= bus.dp;
          blank_a <= bus.blank;
        end else if (pending_valid) begin
          hex_a   <= hex_p;
          dp_a    <= dp_p;
          blank_a <= blank_p;
        end
        pending_valid <= 1'b0;
      end else if (bus.load) begin
        hex_p         <= bus.hex;
        dp_p          <= bus.dp;
        blank_p       <= bus.blank;
        pending_valid <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_hex_sseg_mux.sv
// tb_hex_sseg_mux: directed self-checking bench for hex_sseg_mux
// (N_DIGITS=4, DIGIT_PERIOD=8, GUARD_CYCLES=2, 32-cycle frame).
module tb_hex_sseg_mux;
  logic clk = 1'b0;
  logic reset_n;
  int   n_cmp = 0;
  int   n_err = 0;
  logic [7:0] tab [4];
  logic [3:0] exp_an;
  logic [7:0] exp_ss;
  logic       exp_ft;
  logic       ok;
  int         s, p;

  hex_sseg_mux_if #(.N_DIGITS(4)) bus ();

  hex_sseg_mux #(.N_DIGITS(4), .DIGIT_PERIOD(8), .GUARD_CYCLES(2)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_tick(output logic got);
    got = 1'b0;
    for (int i = 0; i < 64; i++) begin
      step();
      if (bus.frame_tick === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic pulse_load(input logic [15:0] h, input logic [3:0] d, input logic [3:0] b);
    bus.hex = h; bus.dp = d; bus.blank = b; bus.load = 1'b1;
    step();
    bus.load = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    bus.load = 1'b1; bus.hex = 16'h8888; bus.dp = 4'hF; bus.blank = 4'h0;
    repeat (3) step();
    n_cmp++;
    if (bus.an !== 4'hF) begin n_err++; $display("FAIL reset_an: got %b want 1111", bus.an); end
    n_cmp++;
    if (bus.sseg !== 8'hFF) begin n_err++; $display("FAIL reset_sseg: got %h want ff", bus.sseg); end
    n_cmp++;
    if (bus.frame_tick !== 1'b0) begin n_err++; $display("FAIL reset_tick: got %b want 0", bus.frame_tick); end
    reset_n = 1'b1;
    bus.load = 1'b0;
    wait_tick(ok);
    n_cmp++;
    if (ok !== 1'b1) begin n_err++; $display("FAIL reset_tick_timeout: got %b want 1", ok); end
    for (int j = 1; j <= 32; j++) begin
      step();
      s = (j - 1) / 8; p = (j - 1) % 8;
      exp_an = (p < 2) ? 4'hF : ~(4'b0001 << s);
      exp_ss = 8'hFF;
      exp_ft = (j == 32);
      n_cmp++;
      if ({bus.an, bus.sseg, bus.frame_tick} !== {exp_an, exp_ss, exp_ft}) begin
        n_err++;
        $display("FAIL reset_dark j=%0d: got an=%b sseg=%h tick=%b want an=%b sseg=%h tick=%b",
                 j, bus.an, bus.sseg, bus.frame_tick, exp_an, exp_ss, exp_ft);
      end
    end
  endtask

  task automatic test_basic();
    pulse_load(16'h1234, 4'h0, 4'h0);
    wait_tick(ok);
    n_cmp++;
    if (ok !== 1'b1) begin n_err++; $display("FAIL basic_tick_timeout: got %b want 1", ok); end
    tab = '{8'h99, 8'hB0, 8'hA4, 8'hF9};
    for (int j = 1; j <= 32; j++) begin
      step();
      s = (j - 1) / 8; p = (j - 1) % 8;
      exp_an = (p < 2) ? 4'hF : ~(4'b0001 << s);
      exp_ss = (p < 2) ? 8'hFF : tab[s];
      exp_ft = (j == 32);
      n_cmp++;
      if ({bus.an, bus.sseg, bus.frame_tick} !== {exp_an, exp_ss, exp_ft}) begin
        n_err++;
        $display("FAIL basic j=%0d: got an=%b sseg=%h tick=%b want an=%b sseg=%h tick=%b",
                 j, bus.an, bus.sseg, bus.frame_tick, exp_an, exp_ss, exp_ft);
      end
    end
  endtask

  task automatic test_midframe();
    tab = '{8'h99, 8'hB0, 8'hA4, 8'hF9};
    for (int j = 1; j <= 32; j++) begin
      step();
      if (j == 11) bus.load = 1'b0;
      s = (j - 1) / 8; p = (j - 1) % 8;
      exp_an = (p < 2) ? 4'hF : ~(4'b0001 << s);
      exp_ss = (p < 2) ? 8'hFF : tab[s];
      exp_ft = (j == 32);
      n_cmp++;
      if ({bus.an, bus.sseg, bus.frame_tick} !== {exp_an, exp_ss, exp_ft}) begin
        n_err++;
        $display("FAIL midframe_old j=%0d: got an=%b sseg=%h tick=%b want an=%b sseg=%h tick=%b",
                 j, bus.an, bus.sseg, bus.frame_tick, exp_an, exp_ss, exp_ft);
      end
      if (j == 10) begin
        bus.hex = 16'hABCD; bus.dp = 4'h0; bus.blank = 4'h0; bus.load = 1'b1;
      end
    end
    tab = '{8'hA1, 8'hC6, 8'h83, 8'h88};
    for (int j = 1; j <= 32; j++) begin
      step();
      s = (j - 1) / 8; p = (j - 1) % 8;
      exp_an = (p < 2) ? 4'hF : ~(4'b0001 << s);
      exp_ss = (p < 2) ? 8'hFF : tab[s];
      exp_ft = (j == 32);
      n_cmp++;
      if ({bus.an, bus.sseg, bus.frame_tick} !== {exp_an, exp_ss, exp_ft}) begin
        n_err++;
        $display("FAIL midframe_new j=%0d: got an=%b sseg=%h tick=%b want an=%b sseg=%h tick=%b",
                 j, bus.an, bus.sseg, bus.frame_tick, exp_an, exp_ss, exp_ft);
      end
    end
  endtask

  task automatic test_boundary_load();
    repeat (31) step();
    bus.hex = 16'h00F0; bus.dp = 4'h0; bus.blank = 4'h0; bus.load = 1'b1;
    step();
    bus.load = 1'b0;
    n_cmp++;
    if (bus.frame_tick !== 1'b1) begin n_err++; $display("FAIL boundary_tick: got %b want 1", bus.frame_tick); end
    n_cmp++;
    if (dut.pending_valid !== 1'b0) begin n_err++; $display("FAIL boundary_pending: got %b want 0", dut.pending_valid); end
`ifdef HEX_SSEG_MUX_LZB_EN
    tab = '{8'hC0, 8'h8E, 8'hFF, 8'hFF};
`else
    tab = '{8'hC0, 8'h8E, 8'hC0, 8'hC0};
`endif
    for (int f = 0; f < 2; f++) begin
      for (int j = 1; j <= 32; j++) begin
        step();
        s = (j - 1) / 8; p = (j - 1) % 8;
        exp_an = (p < 2) ? 4'hF : ~(4'b0001 << s);
        exp_ss = (p < 2) ? 8'hFF : tab[s];
        exp_ft = (j == 32);
        n_cmp++;
        if ({bus.an, bus.sseg, bus.frame_tick} !== {exp_an, exp_ss, exp_ft}) begin
          n_err++;
          $display("FAIL boundary f=%0d j=%0d: got an=%b sseg=%h tick=%b want an=%b sseg=%h tick=%b",
                   f, j, bus.an, bus.sseg, bus.frame_tick, exp_an, exp_ss, exp_ft);
        end
      end
    end
  endtask

  task automatic test_dp_blank();
    pulse_load(16'h1234, 4'b0100, 4'b0001);
    wait_tick(ok);
    n_cmp++;
    if (ok !== 1'b1) begin n_err++; $display("FAIL dpblank_tick_timeout: got %b want 1", ok); end
    tab = '{8'hFF, 8'hB0, 8'h24, 8'hF9};
    for (int j = 1; j <= 32; j++) begin
      step();
      s = (j - 1) / 8; p = (j - 1) % 8;
      exp_an = (p < 2) ? 4'hF : ~(4'b0001 << s);
      exp_ss = (p < 2) ? 8'hFF : tab[s];
      exp_ft = (j == 32);
      n_cmp++;
      if ({bus.an, bus.sseg, bus.frame_tick} !== {exp_an, exp_ss, exp_ft}) begin
        n_err++;
        $display("FAIL dp_blank j=%0d: got an=%b sseg=%h tick=%b want an=%b sseg=%h tick=%b",
                 j, bus.an, bus.sseg, bus.frame_tick, exp_an, exp_ss, exp_ft);
      end
    end
  endtask

  task automatic test_lzb();
    pulse_load(16'h0050, 4'h0, 4'h0);
    wait_tick(ok);
    n_cmp++;
    if (ok !== 1'b1) begin n_err++; $display("FAIL lzb_tick_timeout: got %b want 1", ok); end
`ifdef HEX_SSEG_MUX_LZB_EN
    tab = '{8'hC0, 8'h92, 8'hFF, 8'hFF};
`else
    tab = '{8'hC0, 8'h92, 8'hC0, 8'hC0};
`endif
    for (int j = 1; j <= 32; j++) begin
      step();
      s = (j - 1) / 8; p = (j - 1) % 8;
      exp_an = (p < 2) ? 4'hF : ~(4'b0001 << s);
      exp_ss = (p < 2) ? 8'hFF : tab[s];
      exp_ft = (j == 32);
      n_cmp++;
      if ({bus.an, bus.sseg, bus.frame_tick} !== {exp_an, exp_ss, exp_ft}) begin
        n_err++;
        $display("FAIL lzb j=%0d: got an=%b sseg=%h tick=%b want an=%b sseg=%h tick=%b",
                 j, bus.an, bus.sseg, bus.frame_tick, exp_an, exp_ss, exp_ft);
      end
    end
  endtask

  task automatic test_reset_mid();
    repeat (9) step();
    pulse_load(16'hFFFF, 4'hF, 4'h0);
    repeat (10) step();
    reset_n = 1'b0;
    bus.hex = 16'h8888; bus.dp = 4'h0; bus.blank = 4'h0; bus.load = 1'b1;
    step();
    n_cmp++;
    if ({bus.an, bus.sseg, bus.frame_tick} !== {4'hF, 8'hFF, 1'b0}) begin
      n_err++;
      $display("FAIL reset_mid: got an=%b sseg=%h tick=%b want an=1111 sseg=ff tick=0",
               bus.an, bus.sseg, bus.frame_tick);
    end
    reset_n = 1'b1;
    bus.load = 1'b0;
    wait_tick(ok);
    n_cmp++;
    if (ok !== 1'b1) begin n_err++; $display("FAIL reset_mid_tick_timeout: got %b want 1", ok); end
    for (int j = 1; j <= 32; j++) begin
      step();
      s = (j - 1) / 8; p = (j - 1) % 8;
      exp_an = (p < 2) ? 4'hF : ~(4'b0001 << s);
      exp_ss = 8'hFF;
      exp_ft = (j == 32);
      n_cmp++;
      if ({bus.an, bus.sseg, bus.frame_tick} !== {exp_an, exp_ss, exp_ft}) begin
        n_err++;
        $display("FAIL reset_mid_dark j=%0d: got an=%b sseg=%h tick=%b want an=%b sseg=%h tick=%b",
                 j, bus.an, bus.sseg, bus.frame_tick, exp_an, exp_ss, exp_ft);
      end
    end
  endtask

  initial begin
    reset_n  = 1'b0;
    bus.load = 1'b0;
    bus.hex  = '0;
    bus.dp   = '0;
    bus.blank = '0;
    test_reset();
    test_basic();
    test_midframe();
    test_boundary_load();
    test_dp_blank();
    test_lzb();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
